// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor slice per clock, LSB first.
// Result and flags are published together on the transition into DONE.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh;
  logic             br, a_msb, b_msb;
  logic             d_bit, br_next, last_bit;
  logic [WIDTH-1:0] result;
  logic             busy_next, done_next;

  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    last_bit = (cnt == CW'(WIDTH - 1));
    // The final difference bit is not in d_sh yet, so splice it in here.
    result   = {d_bit, d_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT; else next_state = IDLE;
      SHIFT:   if (last_bit) next_state = DONE; else next_state = SHIFT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    case (next_state)
      SHIFT:   busy_next = 1'b1;
      DONE:    done_next = 1'b1;
      default: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= borrow_in;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= result;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            diff       <= result;
            borrow_out <= br_next;
            zero       <= (result == '0);
            ovf        <= (a_msb != b_msb) && (d_bit != a_msb);
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=4): stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is high.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         borrow_in;
  logic         busy, done, borrow_out, zero, ovf;
  logic [W-1:0] diff;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow_out", 32'(borrow_out), 32'(e.bo));
        chk("zero", 32'(zero), 32'(e.z));
        chk("ovf", 32'(ovf), 32'(e.ov));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push(input logic [W-1:0] d, input logic bo, input logic z,
                      input logic ov, input int c);
    exp_t e;
    e.d = d; e.bo = bo; e.z = z; e.ov = ov; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
  endtask

  // Issue one operation from IDLE (called at a negedge) and wait for its result.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic ebo, input logic ez, input logic eov);
    a = ia; b = ib; borrow_in = ibin; start = 1'b1;
    push(ed, ebo, ez, eov, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    borrow_in = ~ibin;
    chk("busy_after_accept", 32'(busy), 32'd1);
    drain();
  endtask

  initial begin
    int k;
    logic [W:0] full;
    logic [W-1:0] md;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({borrow_out, zero, ovf}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    do_op(4'd7, 4'd3, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
    do_op(4'd3, 4'd7, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0);
    do_op(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1);
    do_op(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    do_op(4'd5, 4'd2, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    do_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

    // Start pulses during SHIFT and DONE are ignored
    a = 4'd7; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
    k = cyc + 1;
    push(4'h4, 1'b0, 1'b0, 1'b0, k + W);
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignored_starts_queue", 32'(q.size()), 32'd0);
    q.delete();

    // Held start: next acceptance on the first IDLE edge after DONE
    a = 4'd7; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
    k = cyc + 1;
    push(4'h4, 1'b0, 1'b0, 1'b0, k + W);
    @(negedge clk); a = 4'd1; b = 4'd1;
    push(4'h0, 1'b0, 1'b1, 1'b0, k + 2 * W + 2);
    while (cyc < k + W + 2) @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset mid-SHIFT aborts without a done pulse
    a = 4'd9; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_flags", 32'({borrow_out, zero, ovf}), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (8) @(negedge clk);
    do_op(4'd9, 4'd2, 1'b0, 4'h7, 1'b0, 1'b0, 1'b1);

    // Exhaustive sweep against a behavioural model
    for (int i = 0; i < 512; i++) begin
      logic [W-1:0] sa, sb;
      logic sbin;
      sa = W'(i >> 5);
      sb = W'(i >> 1);
      sbin = i[0];
      full = {1'b0, sa} - {1'b0, sb} - {{W{1'b0}}, sbin};
      md = full[W-1:0];
      do_op(sa, sb, sbin, md, full[W], (md == '0),
            (sa[W-1] != sb[W-1]) && (md[W-1] != sa[W-1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor: one full-subtractor slice per clock plus a registered borrow, LSB first.
- Computes a - b - borrow_in over WIDTH cycles.
- Sits beside the combinational ripple subtractor path as the low-area option for the subtract opcode.
- Returns the difference, the final borrow and condition flags to the ALU result/flag stage.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- borrow_in  input  1  initial borrow; captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse when results are valid
- diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH
- borrow_out  output  1  final borrow (unsigned a < b + borrow_in)
- zero  output  1  diff == 0
- ovf  output  1  signed two's-complement overflow

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (asynchronous, any state):
  - state = IDLE; bit counter = 0; internal borrow flop = 0.
  - Operand shift registers = 0.
  - busy = done = 0; diff = 0; borrow_out = zero = ovf = 0.
  - Reset mid-operation aborts with no done pulse. The first start after reset release behaves normally.
- IDLE:
  - start = 1 at edge k: capture a and b into right-shift registers, borrow flop <= borrow_in, save a[WIDTH-1] and b[WIDTH-1], counter <= 0.
  - Go to SHIFT; busy = 1 from edge k.
  - Outputs diff/borrow_out/zero/ovf keep their previous values until the new result lands.
- SHIFT, each edge:
  - d = a0 ^ b0 ^ br.
  - br <= (~a0 & b0) | (~(a0 ^ b0) & br).
  - The diff shift register shifts right with d entering at the MSB; the operand registers shift right.
  - Counter increments.
  - On the edge that processes bit WIDTH-1 (edge k+WIDTH), go to DONE.
- DONE, the single cycle after edge k+WIDTH:
  - done = 1, busy = 0.
  - diff holds the full result; borrow_out = final br.
  - zero = (diff == 0).
  - ovf = (saved a MSB != saved b MSB) && (diff MSB != saved a MSB).
  - Next edge goes to IDLE, done = 0.
- Result latency: start edge to done-high = WIDTH edges. Throughput is one operation per WIDTH+2 cycles.
- Results and flags hold stable from DONE until overwritten by the next completion, or until reset. The shift register is internal and is only copied to diff at the DONE transition, so diff never shows partial bits.
- start in SHIFT or DONE is ignored, and operand inputs are not re-sampled. A held start is accepted again on the first IDLE edge.
- borrow_in only affects the computation through the captured initial borrow. It is not used after the accepting edge.
- Wrap-around: diff is modulo 2^WIDTH; borrow_out reports the underflow.

Test Plan:
1. WIDTH=4, a=7, b=3, borrow_in=0, start one cycle:
   - busy for 4 cycles, then done pulse.
   - diff=4, borrow_out=0, zero=0, ovf=0.
2. a=3, b=7, borrow_in=0:
   - diff=0xC, borrow_out=1, ovf=0.
   - Then a=8, b=1: diff=7, borrow_out=0, ovf=1 (signed -8-1).
3. a=5, b=5, borrow_in=0:
   - diff=0, zero=1, borrow_out=0.
   - Then a=5, b=2, borrow_in=1: diff=2, zero=0.
   - Then a=0, b=0, borrow_in=1: diff=0xF, borrow_out=1, ovf=0.
4. Start a=7, b=3; pulse start again with a=1, b=1 on cycles 2 and 5 after acceptance:
   - Second request ignored; one done pulse with diff=4.
   - Holding start high through DONE gives the next acceptance in IDLE; second done occurs 2 cycles after the first plus WIDTH.
5. Start a=9, b=2; assert rst asynchronously mid-SHIFT (between edges):
   - All outputs go to 0 immediately and no done pulse.
   - After release, a=9, b=2 gives diff=7, borrow_out=0, ovf=1.
6. Sweep all 512 combinations of a, b, borrow_in at WIDTH=4 against a behavioural model:
   - diff, borrow_out, zero and ovf match.
   - done asserts exactly WIDTH edges after every accepted start.
